// File: rtl/snake_navigation.sv
// ============================================================================
// Module   : snake_navigation
// Purpose  : Debounced 4-button direction input, 2-entry move queue, and
//            game-tick driven snake heading register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module snake_navigation #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTNU,
    input  logic       BTND,
    input  logic       BTNL,
    input  logic       BTNR,
    input  logic       GAMECLOCK,
    input  logic [1:0] MASTER_STATE,
    output logic [1:0] NAVIGATION_STATE,
    output logic       DIR_CHANGED,
    output logic [1:0] QUEUE_COUNT
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    localparam logic [1:0] MS_IDLE   = 2'b00;
    localparam logic [1:0] MS_PLAY   = 2'b01;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    // Button index order doubles as priority order: 0 = up (highest).
    logic [3:0] btn_raw;
    logic [3:0] btn_s1_q,   btn_s1_d;
    logic [3:0] btn_s2_q,   btn_s2_d;
    logic [3:0] deb_prev_q, deb_prev_d;
    logic [3:0] deb_level;
    logic [3:0] press;

    assign btn_raw = {BTNR, BTNL, BTND, BTNU};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (!btn_s2_q[gi]) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign deb_level[gi] = (cnt_q == CNT_MAX);
        end
    endgenerate

    assign press = deb_level & ~deb_prev_q;

    always_comb begin
        btn_s1_d   = btn_raw;
        btn_s2_d   = btn_s1_q;
        deb_prev_d = deb_level;
    end

    logic gc_s1_q,   gc_s1_d;
    logic gc_s2_q,   gc_s2_d;
    logic gc_prev_q, gc_prev_d;
    logic tick;

    always_comb begin
        gc_s1_d   = GAMECLOCK;
        gc_s2_d   = gc_s1_q;
        gc_prev_d = gc_s2_q;
    end

    assign tick = gc_s2_q & ~gc_prev_q;

    logic       cand_valid;
    logic [1:0] cand_dir;

    always_comb begin
        cand_valid = |press;
        cand_dir   = DIR_RIGHT;
        if (press[0]) begin
            cand_dir = DIR_UP;
        end else if (press[1]) begin
            cand_dir = DIR_DOWN;
        end else if (press[2]) begin
            cand_dir = DIR_LEFT;
        end
    end

    logic [1:0][1:0] fifo_q,   fifo_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic [1:0]      count_q,  count_d;
    logic [1:0]      nav_q,    nav_d;
    logic            dir_chg_q, dir_chg_d;

    logic [1:0] ref_dir;
    logic       enq;
    logic       pop;

    // The tail sits just behind the write pointer; with a 2-deep FIFO that is ~wr_ptr.
    assign ref_dir = (count_q != 2'd0) ? fifo_q[~wr_ptr_q] : nav_q;

    always_comb begin
        fifo_d    = fifo_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        nav_d     = nav_q;
        dir_chg_d = 1'b0;
        enq       = 1'b0;
        pop       = 1'b0;

        if (MASTER_STATE != MS_PLAY) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
            if (MASTER_STATE == MS_IDLE) begin
                nav_d = DIR_RIGHT;
            end
        end else begin
            enq = cand_valid && (count_q < 2'd2) && (cand_dir != ref_dir) &&
                  ((cand_dir ^ ref_dir) != 2'b11);
            pop = tick && (count_q != 2'd0);

            if (pop) begin
                nav_d     = fifo_q[rd_ptr_q];
                rd_ptr_d  = ~rd_ptr_q;
                dir_chg_d = 1'b1;
            end
            if (enq) begin
                fifo_d[wr_ptr_q] = cand_dir;
                wr_ptr_d         = ~wr_ptr_q;
            end
            count_d = count_q + {1'b0, enq} - {1'b0, pop};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            deb_prev_q <= '0;
            gc_s1_q    <= 1'b0;
            gc_s2_q    <= 1'b0;
            gc_prev_q  <= 1'b0;
            fifo_q     <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            nav_q      <= DIR_RIGHT;
            dir_chg_q  <= 1'b0;
        end else begin
            btn_s1_q   <= btn_s1_d;
            btn_s2_q   <= btn_s2_d;
            deb_prev_q <= deb_prev_d;
            gc_s1_q    <= gc_s1_d;
            gc_s2_q    <= gc_s2_d;
            gc_prev_q  <= gc_prev_d;
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            nav_q      <= nav_d;
            dir_chg_q  <= dir_chg_d;
        end
    end

    assign NAVIGATION_STATE = nav_q;
    assign DIR_CHANGED      = dir_chg_q;
    assign QUEUE_COUNT      = count_q;

endmodule

`default_nettype wire

// File: tb/tb_snake_navigation.sv
// ============================================================================
// Module   : tb_snake_navigation
// Purpose  : Directed and random stimulus for snake_navigation, checked every
//            cycle against a queue-based behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_snake_navigation;

    localparam int DEB = 4;
    localparam logic [1:0] IDLE = 2'b00, PLAY = 2'b01, WIN = 2'b10, LOSE = 2'b11;
    localparam logic [3:0] B_U = 4'b0001, B_D = 4'b0010, B_L = 4'b0100, B_R = 4'b1000;

    logic       clk = 1'b0;
    logic       rst, bu, bd, bl, br, gc;
    logic [1:0] ms;
    logic [1:0] nav;
    logic       dc;
    logic [1:0] qc;

    always #5 clk = ~clk;

    snake_navigation #(.DEBOUNCE_CYCLES(DEB)) dut (
        .CLK              (clk),
        .RESET            (rst),
        .BTNU             (bu),
        .BTND             (bd),
        .BTNL             (bl),
        .BTNR             (br),
        .GAMECLOCK        (gc),
        .MASTER_STATE     (ms),
        .NAVIGATION_STATE (nav),
        .DIR_CHANGED      (dc),
        .QUEUE_COUNT      (qc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Reference model: inputs are seen through a 2-flop synchroniser, so a
    // button press lands 3 edges after its final debounce sample and a tick
    // lands 2 edges after the game clock is first sampled high.
    logic [3:0] bh [4];
    logic       gh [4];
    int         run [4];
    logic [1:0] m_nav;
    logic       m_dc;
    logic [1:0] mq [$];

    function automatic logic [1:0] btn_dir(input int k);
        case (k)
            0:       return 2'b10;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic bit is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a == 2'b00 && b == 2'b11) || (a == 2'b11 && b == 2'b00) ||
               (a == 2'b01 && b == 2'b10) || (a == 2'b10 && b == 2'b01);
    endfunction

    task automatic model_step(input logic r, input logic [3:0] b, input logic g, input logic [1:0] m);
        bit         have;
        bit         tick;
        logic [1:0] cand;
        logic [1:0] refd;
        int         n0;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                bh[i] = '0; gh[i] = 1'b0; run[i] = 0;
            end
            m_nav = 2'b00; m_dc = 1'b0; mq.delete();
            return;
        end
        for (int i = 3; i > 0; i--) begin
            bh[i] = bh[i-1]; gh[i] = gh[i-1];
        end
        bh[0] = b; gh[0] = g;
        have = 1'b0; cand = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (bh[3][k]) run[k] = (run[k] > DEB) ? run[k] : run[k] + 1;
            else          run[k] = 0;
            if (run[k] == DEB && !have) begin
                have = 1'b1; cand = btn_dir(k);
            end
        end
        tick = gh[2] && !gh[3];
        m_dc = 1'b0;
        if (m != PLAY) begin
            mq.delete();
            if (m == IDLE) m_nav = 2'b00;
        end else begin
            n0   = mq.size();
            refd = (n0 > 0) ? mq[n0-1] : m_nav;
            if (tick && n0 > 0) begin
                m_nav = mq.pop_front();
                m_dc  = 1'b1;
            end
            if (have && n0 < 2 && cand != refd && !is_reverse(cand, refd))
                mq.push_back(cand);
        end
    endtask

    task automatic cycle(input logic r, input logic [3:0] b, input logic g, input logic [1:0] m);
        rst = r; {br, bl, bd, bu} = b; gc = g; ms = m;
        @(posedge clk);
        model_step(r, b, g, m);
        #1;
        check_value("nav_state",   32'(nav), 32'(m_nav));
        check_value("dir_changed", 32'(dc),  32'(m_dc));
        check_value("queue_count", 32'(qc),  32'(mq.size()));
    endtask

    task automatic hold(input int n, input logic r, input logic [3:0] b, input logic g, input logic [1:0] m);
        repeat (n) cycle(r, b, g, m);
    endtask

    task automatic press_btn(input logic [3:0] b, input int len);
        hold(len, 1'b0, b, 1'b0, PLAY);
        hold(3, 1'b0, 4'b0, 1'b0, PLAY);
    endtask

    task automatic game_tick();
        hold(4, 1'b0, 4'b0, 1'b1, PLAY);
        hold(4, 1'b0, 4'b0, 1'b0, PLAY);
    endtask

    initial begin
        logic [3:0] bv;
        logic [1:0] mv;
        logic       gv;
        int         gcnt;
        int         len;

        hold(3, 1'b1, 4'b0, 1'b0, IDLE);

        // Single press then tick: heading moves to down.
        hold(20, 1'b0, B_D, 1'b0, PLAY);
        hold(4, 1'b0, 4'b0, 1'b0, PLAY);
        game_tick();

        // Reversal and same-direction presses are dropped.
        hold(2, 1'b1, 4'b0, 1'b0, PLAY);
        press_btn(B_L, 8);
        press_btn(B_R, 8);

        // Fill the queue, overflow press, then drain with two ticks.
        press_btn(B_U, 8);
        press_btn(B_L, 8);
        press_btn(B_D, 8);
        game_tick();
        game_tick();

        // Glitchy button followed by a clean hold.
        hold(3, 1'b0, B_U, 1'b0, PLAY);
        hold(1, 1'b0, 4'b0, 1'b0, PLAY);
        hold(3, 1'b0, B_U, 1'b0, PLAY);
        hold(3, 1'b0, 4'b0, 1'b0, PLAY);
        hold(6, 1'b0, B_U, 1'b0, PLAY);
        hold(3, 1'b0, 4'b0, 1'b0, PLAY);

        // Simultaneous presses resolve by priority.
        hold(2, 1'b1, 4'b0, 1'b0, PLAY);
        press_btn(B_U | B_L, 8);
        game_tick();

        // Tick and enqueue coinciding with one entry queued.
        press_btn(B_L, 8);
        for (int d = 0; d < 6; d++) begin
            hold(2, 1'b1, 4'b0, 1'b0, PLAY);
            press_btn(B_U, 8);
            hold(d, 1'b0, B_R, 1'b0, PLAY);
            hold(2, 1'b0, B_R, 1'b1, PLAY);
            hold(6, 1'b0, B_R, 1'b0, PLAY);
            hold(3, 1'b0, 4'b0, 1'b0, PLAY);
        end

        // Mode changes flush the queue; reset lands mid-tick.
        press_btn(B_D, 8);
        press_btn(B_R, 8);
        hold(3, 1'b0, 4'b0, 1'b0, LOSE);
        hold(3, 1'b0, 4'b0, 1'b0, IDLE);
        press_btn(B_D, 8);
        hold(2, 1'b0, 4'b0, 1'b1, PLAY);
        hold(1, 1'b1, 4'b0, 1'b1, PLAY);
        hold(6, 1'b0, B_L, 1'b1, PLAY);
        hold(4, 1'b0, 4'b0, 1'b0, PLAY);

        // Randomised play.
        gv = 1'b0; gcnt = 5; mv = PLAY;
        for (int s = 0; s < 700; s++) begin
            case ($urandom_range(0, 9))
                0, 1:    bv = 4'b0;
                2:       bv = 4'($urandom_range(0, 15));
                default: bv = 4'b0001 << $urandom_range(0, 3);
            endcase
            if ($urandom_range(0, 19) == 0) begin
                mv = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : PLAY;
            end
            len = $urandom_range(1, 9);
            for (int c = 0; c < len; c++) begin
                if (gcnt == 0) begin
                    gv   = ~gv;
                    gcnt = $urandom_range(2, 10);
                end else begin
                    gcnt--;
                end
                cycle(($urandom_range(0, 299) == 0), bv, gv, mv);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/snake_navigation.md
SNAKE_NAVIGATION -- requirements
Module: snake_navigation

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 500000, consecutive CLK cycles a synchronised button must stay high before it counts as pressed (10 ms at 50 MHz).
REQ-002 Port: CLK  input  1  system clock; the only clock; all state SHALL update on its rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-high reset.
REQ-004 Port: BTNU / BTND / BTNL / BTNR  input  1 each  raw asynchronous push buttons (up, down, left, right), active high.
REQ-005 Port: GAMECLOCK  input  1  slow game-step clock treated as a data level; only its rising edge is used.
REQ-006 Port: MASTER_STATE  input  2  game mode: 00 IDLE, 01 PLAY, 10 WIN, 11 LOSE.
REQ-007 Port: NAVIGATION_STATE  output  2  current snake direction: 00 right, 01 down, 10 up, 11 left.
REQ-008 Port: DIR_CHANGED  output  1  one-cycle pulse when NAVIGATION_STATE is loaded from the queue.
REQ-009 Port: QUEUE_COUNT  output  2  number of pending directions (0..2).

Function
REQ-010 Each button and GAMECLOCK SHALL pass through a 2-flop synchroniser before any other use.
REQ-011 Per button: counter SHALL increment while synchronised input is high, clear to 0 when low, saturate at DEBOUNCE_CYCLES; debounced level = (counter == DEBOUNCE_CYCLES).
REQ-012 Press event SHALL be a one-cycle pulse on the rising edge of a debounced level; holding a button produces exactly one event.
REQ-013 Same-cycle multiple press events SHALL resolve by priority U > D > L > R; lower-priority events that cycle are discarded.
REQ-014 Pending directions SHALL be held in a 2-entry FIFO.
REQ-015 Reference direction = FIFO tail if QUEUE_COUNT > 0, else NAVIGATION_STATE.
REQ-016 Candidate SHALL be enqueued only if MASTER_STATE == PLAY, QUEUE_COUNT < 2 (value before any same-cycle pop), candidate != reference, and (candidate XOR reference) != 11 (no reversal); otherwise dropped silently.
REQ-017 Game tick = synchronised GAMECLOCK high and previous synchronised value low.
REQ-018 On game tick with MASTER_STATE == PLAY and QUEUE_COUNT > 0: NAVIGATION_STATE <= FIFO head, head popped, DIR_CHANGED = 1 next cycle; tick with empty FIFO SHALL leave NAVIGATION_STATE unchanged and DIR_CHANGED = 0.
REQ-019 Latency: NAVIGATION_STATE SHALL change on the 3rd CLK rising edge after GAMECLOCK is first sampled high.
REQ-020 Simultaneous enqueue and pop SHALL both take effect; QUEUE_COUNT net unchanged; reversal check uses pre-pop tail.
REQ-021 MASTER_STATE != PLAY: FIFO flushed (QUEUE_COUNT = 0), no enqueue, no pop, DIR_CHANGED = 0.
REQ-022 MASTER_STATE == IDLE: NAVIGATION_STATE SHALL be forced to 00; in WIN/LOSE it SHALL hold its value.
REQ-023 QUEUE_COUNT SHALL never exceed 2 or underflow below 0.

Reset
REQ-024 RESET high at a CLK edge SHALL set NAVIGATION_STATE = 00, DIR_CHANGED = 0, QUEUE_COUNT = 0, FIFO pointers 0, all debounce counters 0, all synchroniser and edge registers 0.
REQ-025 RESET SHALL take priority over every other event in the same cycle, including a mid-operation tick or press.
REQ-026 A GAMECLOCK or button already high at reset release SHALL be treated as a fresh rising edge (tick/press after normal latency).

Verification (DEBOUNCE_CYCLES = 4)
REQ-027 Reset, PLAY, press BTND 20 cycles, then GAMECLOCK rise -> QUEUE_COUNT 1 after debounce; NAVIGATION_STATE 01 at 3rd edge; DIR_CHANGED one cycle; QUEUE_COUNT 0.
REQ-028 NAVIGATION_STATE 00, press BTNL -> dropped (reversal), QUEUE_COUNT stays 0; press BTNR -> dropped (same).
REQ-029 NAVIGATION_STATE 00, press U, then L, then D before any tick -> queue {10,11}; D dropped (full); two ticks -> 10 then 11.
REQ-030 Glitchy button: BTNU high 3 cycles, low 1, high 3 -> no event; high 6 cycles -> exactly one event.
REQ-031 BTNU and BTNL pressed same cycle -> only 10 enqueued; tick and enqueue in same cycle with count 1 -> count remains 1, correct order.
REQ-032 Queue 2 entries, MASTER_STATE -> LOSE -> QUEUE_COUNT 0, NAVIGATION_STATE held; -> IDLE -> NAVIGATION_STATE 00; RESET mid-tick -> all outputs 0.
